// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
//
// Shared constants and types for the CORDIC datapath and its fixed-point to
// float converter.
//
// Contents:
//   FIX_W       width of the CORDIC fixed-point result
//   FLT_W       width of an IEEE-754 single-precision word
//   FLT_BIAS    single-precision exponent bias
//   FLT_MANT_W  stored mantissa width (hidden bit excluded)
//   FLT_EXP_W   biased exponent width
//   float32_t   packed {sign, exp, mant} view of a single-precision word
//   pack_float  assembles a non-negative float32_t, forcing +0.0 for zero
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam int FIX_W      = 32;
    localparam int FLT_W      = 32;
    localparam int FLT_BIAS   = 127;
    localparam int FLT_MANT_W = 23;
    localparam int FLT_EXP_W  = 8;

    typedef struct packed {
        logic                  sign;
        logic [FLT_EXP_W-1:0]  exp;
        logic [FLT_MANT_W-1:0] mant;
    } float32_t;

    // The converter only ever produces non-negative values, so the sign is
    // tied low; a zero input collapses to all-zero bits (no negative zero).
    function automatic float32_t pack_float(
        input logic                  zero,
        input logic [FLT_EXP_W-1:0]  exp,
        input logic [FLT_MANT_W-1:0] mant
    );
        float32_t f;
        f.sign = 1'b0;
        f.exp  = exp;
        f.mant = mant;
        if (zero) begin
            f = '0;
        end
        return f;
    endfunction

endpackage

// File: rtl/fix2float_lzc32.sv
// ---------------------------------------------------------------------------
// lzc32
//
// Combinational 32-bit leading-zero counter.
//
// Ports:
//   data   in   32  value to scan
//   count  out   6  number of leading zeros, 0..32 (32 for an all-zero input)
// ---------------------------------------------------------------------------
module lzc32 (
    input  logic [31:0] data,
    output logic [5:0]  count
);

    // Scan from the LSB upward so the highest set bit is the last to write.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (data[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fix2float.sv
// ---------------------------------------------------------------------------
// fix2float
//
// Three-stage pipelined converter from the CORDIC unsigned fixed-point result
// (1 integer bit, FRAC_W fractional bits; value = in_data * 2^-FRAC_W) to an
// IEEE-754 single-precision word. One conversion per cycle, valid/ready on
// both sides, whole-pipeline stall when the output is held.
//
// Parameters:
//   FRAC_W     binary-point position in in_data, 0..31
//
// Ports:
//   clk        in    1  rising-edge clock
//   rst_n      in    1  asynchronous active-low reset
//   in_valid   in    1  in_data is valid
//   in_ready   out   1  converter accepts in_data this cycle
//   in_data    in   32  unsigned fixed-point input
//   out_valid  out   1  out_data is valid
//   out_ready  in    1  consumer accepts out_data this cycle
//   out_data   out  32  single-precision result (sign always 0)
//
// Build option:
//   FIX2FLOAT_RNE_EN  defined   -> round to nearest even
//                     undefined -> truncate toward zero
// ---------------------------------------------------------------------------
module fix2float
    import cordic_pkg::*;
#(
    parameter int FRAC_W = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLT_W-1:0] out_data
);

    // Biased exponent of a value whose MSB sits at bit 31 of the word.
    localparam logic signed [8:0] EXP_OFS = 9'(FLT_BIAS + FIX_W - 1 - FRAC_W);

    logic adv;

    logic             vld_p0;
    logic [FIX_W-1:0] data_p0;
    logic [5:0]       lz_p0;
    logic             zero_p0;

    logic             vld_p1;
    logic [FIX_W-1:0] norm_p1;
    logic signed [8:0] exp_p1;
    logic             zero_p1;

    logic             vld_p2;
    float32_t         res_p2;

    logic [5:0]             lz_c;
    logic [FIX_W-1:0]       norm_c;
    logic signed [8:0]      exp_c;
    logic [FLT_EXP_W-1:0]   exp_r;
    logic [FLT_MANT_W-1:0]  mant_r;
    float32_t               res_c;
    logic                   unused_bits;

`ifdef FIX2FLOAT_RNE_EN
    // Round-to-nearest-even on the 23-bit mantissa. A carry out of the
    // mantissa bumps the exponent; exp never exceeds 158 so it cannot
    // overflow into infinity.
    function automatic logic [FLT_EXP_W+FLT_MANT_W-1:0] round_rne(
        input logic [FLT_EXP_W-1:0]  exp,
        input logic [FLT_MANT_W-1:0] mant,
        input logic                  g,
        input logic                  s
    );
        logic [FLT_EXP_W-1:0]  e;
        logic [FLT_MANT_W-1:0] m;
        logic [FLT_MANT_W:0]   m_inc;
        e     = exp;
        m     = mant;
        m_inc = {1'b0, mant} + {{FLT_MANT_W{1'b0}}, 1'b1};
        if (g && (s || mant[0])) begin
            m = m_inc[FLT_MANT_W-1:0];
            if (m_inc[FLT_MANT_W]) begin
                e = exp + 8'd1;
            end
        end
        return {e, m};
    endfunction
`endif

    // Every stage moves together; a held output freezes the whole pipe.
    assign adv       = !vld_p2 || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p2;
    assign out_data  = res_p2;

    // ---- stage 0: capture input, count leading zeros ----
    lzc32 u_lzc (
        .data  (in_data),
        .count (lz_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            data_p0 <= in_data;
            lz_p0   <= lz_c;
            zero_p0 <= (in_data == '0);
        end
    end

    // ---- stage 1: normalise and form the biased exponent ----
    // A shift of 32 (zero input) yields zero, which the zero flag masks anyway.
    assign norm_c = data_p0 << lz_p0;
    assign exp_c  = EXP_OFS - $signed({3'b000, lz_p0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            norm_p1 <= norm_c;
            exp_p1  <= exp_c;
            zero_p1 <= zero_p0;
        end
    end

    // ---- stage 2: round and pack ----
    // exp_p1 lies in 96..158, so bit 8 is always clear and only the low
    // eight bits reach the result.
`ifdef FIX2FLOAT_RNE_EN
    assign {exp_r, mant_r} = round_rne(exp_p1[7:0], norm_p1[30:8],
                                       norm_p1[7], |norm_p1[6:0]);
    assign unused_bits     = exp_p1[8] ^ norm_p1[31];
`else
    assign exp_r       = exp_p1[7:0];
    assign mant_r      = norm_p1[30:8];
    assign unused_bits = ^{exp_p1[8], norm_p1[31], norm_p1[7:0]};
`endif

    assign res_c = pack_float(zero_p1, exp_r, mant_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            // Bubbles leave the last result in place rather than garbage.
            if (vld_p1) begin
                res_p2 <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_fix2float.sv
module tb_fix2float;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [31:0] data_f0;
    logic [31:0] data_f16;

    logic        in_ready,  out_valid;
    logic [31:0] out_data;
    logic        rdy_f0,  vld_f0;
    logic [31:0] q_f0;
    logic        rdy_f16, vld_f16;
    logic [31:0] q_f16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fix2float #(.FRAC_W(31)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    fix2float #(.FRAC_W(0)) dut_f0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f0),
        .in_data(data_f0), .out_valid(vld_f0), .out_ready(out_ready),
        .out_data(q_f0)
    );

    fix2float #(.FRAC_W(16)) dut_f16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f16),
        .in_data(data_f16), .out_valid(vld_f16), .out_ready(out_ready),
        .out_data(q_f16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: go through a double and round its 52-bit
    // mantissa down to 23 bits.
    function automatic logic [31:0] ref_f(input logic [31:0] x, input int frac);
        real         r;
        logic [63:0] d;
        logic [7:0]  e;
        logic [22:0] m;
        logic [23:0] mi;
        if (x == 32'd0) return 32'd0;
        r  = real'(longint'({32'd0, x})) / (2.0 ** frac);
        d  = $realtobits(r);
        e  = 8'(int'(d[62:52]) - 1023 + 127);
        m  = d[51:29];
`ifdef FIX2FLOAT_RNE_EN
        if (d[28] && ((|d[27:0]) || m[0])) begin
            mi = {1'b0, m} + 24'd1;
            m  = mi[22:0];
            if (mi[23]) e = e + 8'd1;
        end
`endif
        return {1'b0, e, m};
    endfunction

    // One isolated conversion on the FRAC_W=31 instance, checking latency.
    task automatic run_one(input logic [31:0] din, input logic [31:0] exp, input string tag);
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_lat2"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_lat3_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, exp);
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] bp_in  [6];
    logic [31:0] bp_exp [6];
    logic [31:0] tp_exp [$];

    initial begin
        logic        rdy_b, ov_b, or_b;
        logic [31:0] od_b;
        logic [31:0] x;
        int          sent, got, held_low;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'd0;
        data_f0   = 32'd0;
        data_f16  = 32'd0;

        // Reset state
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  out_data,       32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        #10 rst_n = 1'b1;

        // Basic values
        run_one(32'h8000_0000, 32'h3F80_0000, "one");
        run_one(32'h4000_0000, 32'h3F00_0000, "half");
        run_one(32'h0000_0001, 32'h3000_0000, "lsb");
        run_one(32'h0000_0000, 32'h0000_0000, "zero");

        // Rounding
`ifdef FIX2FLOAT_RNE_EN
        run_one(32'h8000_0080, 32'h3F80_0000, "tie_even");
        run_one(32'h8000_0180, 32'h3F80_0002, "tie_odd");
        run_one(32'h8000_00C0, 32'h3F80_0001, "above_half");
        run_one(32'hFFFF_FFFF, 32'h4000_0000, "mant_carry");
`else
        run_one(32'h8000_0080, 32'h3F80_0000, "tie_even");
        run_one(32'h8000_0180, 32'h3F80_0001, "tie_odd");
        run_one(32'h8000_00C0, 32'h3F80_0000, "above_half");
        run_one(32'hFFFF_FFFF, 32'h3FFF_FFFF, "mant_carry");
`endif

        // Backpressure: out_ready low for loop cycles 4..8
        bp_in[0] = 32'h8000_0000; bp_exp[0] = 32'h3F80_0000;
        bp_in[1] = 32'h4000_0000; bp_exp[1] = 32'h3F00_0000;
        bp_in[2] = 32'h2000_0000; bp_exp[2] = 32'h3E80_0000;
        bp_in[3] = 32'h0000_0001; bp_exp[3] = 32'h3000_0000;
        bp_in[4] = 32'hC000_0000; bp_exp[4] = 32'h3FC0_0000;
        bp_in[5] = 32'h6000_0000; bp_exp[5] = 32'h3F40_0000;
        sent = 0; got = 0; held_low = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            in_valid  = (sent < 6);
            in_data   = (sent < 6) ? bp_in[sent] : 32'd0;
            out_ready = !(c >= 4 && c <= 8);
            #1;
            rdy_b = in_ready; ov_b = out_valid; or_b = out_ready; od_b = out_data;
            if (ov_b && !or_b) begin
                check("bp_in_ready_low", 32'(rdy_b), 32'd0);
                held_low++;
            end
            tick();
            if (in_valid && rdy_b) sent++;
            if (ov_b && or_b) begin
                check("bp_order", od_b, bp_exp[got]);
                got++;
            end else if (ov_b) begin
                check("bp_stable_valid", 32'(out_valid), 32'd1);
                check("bp_stable_data",  out_data, od_b);
            end
        end
        in_valid = 1'b0;
        check("bp_sent",       32'(sent),     32'd6);
        check("bp_got",        32'(got),      32'd6);
        check("bp_stall_cyc",  32'(held_low), 32'd5);
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Full throughput with random inputs
        out_ready = 1'b1;
        for (int c = 0; c < 103; c++) begin
            if (c < 100) begin
                x        = $urandom >> $urandom_range(0, 31);
                in_data  = x;
                in_valid = 1'b1;
                tp_exp.push_back(ref_f(x, 31));
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 2 && c <= 101) begin
                check("tp_valid", 32'(out_valid), 32'd1);
                if (tp_exp.size() > 0) check("tp_data", out_data, tp_exp.pop_front());
            end
            if (c == 102) check("tp_end", 32'(out_valid), 32'd0);
        end

        // Reset with three items in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0000; tick();
        in_data   = 32'h4000_0000; tick();
        in_data   = 32'h2000_0000; tick();
        in_valid  = 1'b0;
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        tick();
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b1;
        run_one(32'hC000_0000, 32'h3FC0_0000, "post_rst");

        // Parameter sweep
        in_data   = 32'd0;
        data_f0   = 32'h0000_0001;
        data_f16  = 32'h0001_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        data_f0  = 32'h0000_0003;
        data_f16 = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        tick();
        check("f0_valid",   32'(vld_f0),  32'd1);
        check("f0_one",     q_f0,         32'h3F80_0000);
        check("f16_valid",  32'(vld_f16), 32'd1);
        check("f16_one",    q_f16,        32'h3F80_0000);
        check("f31_zero",   out_data,     32'h0000_0000);
        tick();
        check("f0_three",   q_f0,         32'h4040_0000);
`ifdef FIX2FLOAT_RNE_EN
        check("f16_max",    q_f16,        32'h4780_0000);
`else
        check("f16_max",    q_f16,        32'h477F_FFFF);
`endif
        tick();
        check("sweep_drained", 32'(vld_f0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
